wsg_voice_scheduler: RTL and testbench

Time-multiplexed sequencer for the 3-voice Namco WSG sound datapath. It owns the 32x4 sound register file written by the Z80, divides clk_pixel down to a 72 kHz slot rate and walks voices 0..2 in turn. For each voice it drives a wave-PROM read, scales the returned sample by volume and accumulates it. It emits one mixed signed sample per 24 kHz frame to the HDMI audio path.

---
 rtl/wsg_pkg.sv | 18 +
 rtl/wsg_regfile.sv | 46 ++++
 rtl/wsg_voice_scheduler.sv | 163 ++++++++++++++++
 tb/tb_wsg_voice_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wsg_pkg.sv
// Shared types and register-map constants for the Namco WSG voice scheduler.
package wsg_pkg;

    localparam logic [4:0] WAVE_BASE    = 5'h05;
    localparam logic [4:0] FREQ_BASE    = 5'h10;
    localparam logic [4:0] VOL_BASE     = 5'h15;
    localparam logic [4:0] VOICE_STRIDE = 5'd5;
    localparam int         NUM_VOICES   = 3;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACC} wsg_state_t;
    typedef logic [19:0]        phase_t;
    typedef logic signed [9:0]  mix_t;

    function automatic logic [4:0] voice_offset(input logic [1:0] voice);
        return {3'b000, voice} * VOICE_STRIDE;
    endfunction

endpackage

// File: rtl/wsg_regfile.sv
// 32x4 sound register file: CPU write port plus a combinational per-voice view.
module wsg_regfile
    import wsg_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [3:0] wdata,
    input  logic [1:0] voice,
    output logic [3:0] wave,
    output logic [3:0] volume,
    output phase_t     freq
);

    logic [3:0] regs_q [32];
    logic [3:0] regs_d [32];
    logic [4:0] off;
    logic [3:0] low;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: 4'h0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Only voice 0 owns a low frequency nibble; the others run at 16x granularity.
    always_comb begin
        off    = voice_offset(voice);
        low    = (voice == 2'd0) ? regs_q[FREQ_BASE] : 4'h0;
        wave   = regs_q[WAVE_BASE + off];
        volume = regs_q[VOL_BASE + off];
        freq   = {regs_q[FREQ_BASE + off + 5'd4], regs_q[FREQ_BASE + off + 5'd3],
                  regs_q[FREQ_BASE + off + 5'd2], regs_q[FREQ_BASE + off + 5'd1], low};
    end

endmodule

// File: rtl/wsg_voice_scheduler.sv
// Time-multiplexed 3-voice WSG sequencer: slot divider, PROM fetch, volume scale, mix.
// Optional build macro WSG_MUTE_MASK_EN adds a per-voice mute_mask input.
module wsg_voice_scheduler
    import wsg_pkg::*;
#(
    parameter int PIXEL_CLOCK = 34800000,
    parameter int SLOT_RATE   = 72000
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       reg_we,
    input  logic [4:0] reg_addr,
    input  logic [3:0] reg_wdata,
    output logic       rom_rd,
    output logic [7:0] rom_addr,
    input  logic [3:0] rom_data_a,
    input  logic [3:0] rom_data_b,
`ifdef WSG_MUTE_MASK_EN
    input  logic [2:0] mute_mask,
`endif
    output logic [9:0] sample_out,
    output logic       sample_valid,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    localparam int DIV = PIXEL_CLOCK / SLOT_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    wsg_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    voice_q, voice_d;
    phase_t        phase_q [NUM_VOICES];
    phase_t        phase_d [NUM_VOICES];
    mix_t          sum_q, sum_d, sample_out_q, sample_out_d, contrib;
    logic          pending_q, pending_d, overrun_q, overrun_d;
    logic          sample_valid_q, sample_valid_d, tick;
    logic [7:0]    rom_addr_q, rom_addr_d;
    logic [3:0]    wave_q, wave_d, vol_q, vol_d, rf_wave, rf_volume, sel;
    phase_t        freq_q, freq_d, rf_freq;
    logic signed [11:0] samp, prod;

    wsg_regfile u_regfile (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .we        (reg_we),
        .addr      (reg_addr),
        .wdata     (reg_wdata),
        .voice     (voice_q),
        .wave      (rf_wave),
        .volume    (rf_volume),
        .freq      (rf_freq)
    );

    // Handshake: rom_rd is a one-cycle strobe with rom_addr; PROM data is consumed two
    // cycles later (ACC). sample_valid is a one-cycle strobe; sample_out holds between strobes.
    always_comb begin
        sel     = wave_q[3] ? rom_data_b : rom_data_a;
        samp    = $signed({8'b0, sel}) - 12'sd7;
        prod    = $signed({8'b0, vol_q}) * samp;
        contrib = $signed(prod[9:0]);
`ifdef WSG_MUTE_MASK_EN
        if (mute_mask[voice_q]) begin
            contrib = '0;
        end
`endif
    end

    always_comb begin
        tick           = (count_q == CW'(DIV - 1));
        count_d        = tick ? '0 : count_q + CW'(1);
        state_d        = state_q;
        voice_d        = voice_q;
        phase_d        = phase_q;
        sum_d          = sum_q;
        pending_d      = pending_q;
        overrun_d      = overrun_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
        rom_addr_d     = rom_addr_q;
        wave_d         = wave_q;
        vol_d          = vol_q;
        freq_d         = freq_q;
        rom_rd         = 1'b0;

        // A busy slot defers one tick; a second deferred tick is lost for good.
        if (tick && state_q != IDLE) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick || pending_q) begin
                    if (tick && pending_q) overrun_d = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                rom_rd     = 1'b1;
                wave_d     = rf_wave;
                vol_d      = rf_volume;
                freq_d     = rf_freq;
                rom_addr_d = {rf_wave[2:0], phase_q[voice_q][17:13]};
                state_d    = WAIT;
            end
            WAIT: state_d = ACC;
            ACC: begin
                phase_d[voice_q] = phase_q[voice_q] + freq_q;
                if (voice_q == 2'd2) begin
                    sample_out_d   = sum_q + contrib;
                    sample_valid_d = 1'b1;
                    voice_d        = 2'd0;
                end else begin
                    sum_d   = ((voice_q == 2'd0) ? mix_t'(0) : sum_q) + contrib;
                    voice_d = voice_q + 2'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            voice_q        <= 2'd0;
            phase_q        <= '{default: '0};
            sum_q          <= '0;
            pending_q      <= 1'b0;
            overrun_q      <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            rom_addr_q     <= '0;
            wave_q         <= '0;
            vol_q          <= '0;
            freq_q         <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            voice_q        <= voice_d;
            phase_q        <= phase_d;
            sum_q          <= sum_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            rom_addr_q     <= rom_addr_d;
            wave_q         <= wave_d;
            vol_q          <= vol_d;
            freq_q         <= freq_d;
        end
    end

    assign rom_addr     = rom_addr_d;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_wsg_voice_scheduler.sv
// Scoreboard bench for wsg_voice_scheduler: directed register setups, monitor-side checking.
module tb_wsg_voice_scheduler;
    import wsg_pkg::*;

    logic       clk_pixel = 1'b0;
    logic       reset_n = 1'b0;
    logic       reg_we = 1'b0;
    logic [4:0] reg_addr = '0;
    logic [3:0] reg_wdata = '0;
    logic [3:0] rom_data_a = '0;
    logic [3:0] rom_data_b = '0;
    logic       rom_rd, sample_valid, overrun;
    logic [7:0] rom_addr;
    logic [9:0] sample_out;
    logic [1:0] dbg_state;
`ifdef WSG_MUTE_MASK_EN
    logic [2:0] mute_mask = 3'b000;
`endif

    logic       s_reset_n = 1'b0;
    logic       s_rom_rd, s_sample_valid, s_overrun;
    logic [7:0] s_rom_addr;
    logic [9:0] s_sample_out;
    logic [1:0] s_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];
    logic [7:0] exp_addr_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    wsg_voice_scheduler dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data_a   (rom_data_a),
        .rom_data_b   (rom_data_b),
`ifdef WSG_MUTE_MASK_EN
        .mute_mask    (mute_mask),
`endif
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    // DIV = 2 makes slot ticks outrun the 4-cycle slot, exercising pending and overrun.
    wsg_voice_scheduler #(.PIXEL_CLOCK(2), .SLOT_RATE(1)) dut_fast (
        .clk_pixel    (clk_pixel),
        .reset_n      (s_reset_n),
        .reg_we       (1'b0),
        .reg_addr     (5'd0),
        .reg_wdata    (4'd0),
        .rom_rd       (s_rom_rd),
        .rom_addr     (s_rom_addr),
        .rom_data_a   (4'd0),
        .rom_data_b   (4'd0),
`ifdef WSG_MUTE_MASK_EN
        .mute_mask    (3'b000),
`endif
        .sample_out   (s_sample_out),
        .sample_valid (s_sample_valid),
        .overrun      (s_overrun),
        .dbg_state    (s_dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [3:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk_pixel);
        reg_we    = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk_pixel);
            n++;
        end while (!sample_valid && n < 2000);
        check("valid_seen", sample_valid, 1);
    endtask

    task automatic frame(input logic [9:0] exp);
        exp_q.push_back(exp);
        wait_valid();
    endtask

    task automatic push_addrs(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        exp_addr_q.push_back(a0);
        exp_addr_q.push_back(a1);
        exp_addr_q.push_back(a2);
    endtask

    task automatic release_reset();
        @(posedge clk_pixel);
        #2 reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_rd"}, rom_rd, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_sample_out"}, sample_out, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- scoreboard monitor ----------------
    int cyc = 0;
    int last_cyc = 0;
    int rd_cnt = 0;
    bit first_pending = 1'b1;

    always @(negedge clk_pixel) begin
        if (!reset_n) begin
            cyc = 0;
            rd_cnt = 0;
            first_pending = 1'b1;
        end else begin
            cyc++;
            if (rom_rd) begin
                rd_cnt++;
                if (exp_addr_q.size() > 0) check("rom_addr", rom_addr, exp_addr_q.pop_front());
            end
            if (sample_valid) begin
                if (exp_q.size() == 0) check("sample_unexpected", 1, 0);
                else                   check("sample_out", sample_out, exp_q.pop_front());
                if (first_pending) begin
                    check("first_valid_cycle", cyc, 1453);
                end else begin
                    check("frame_period", cyc - last_cyc, 1449);
                    check("rom_rd_per_frame", rd_cnt, 3);
                end
                first_pending = 1'b0;
                last_cyc = cyc;
                rd_cnt = 0;
            end
        end
    end

    // ---------------- pending / overrun on the fast instance ----------------
    initial begin
        repeat (2) @(negedge clk_pixel);
        @(posedge clk_pixel);
        #2 s_reset_n = 1'b1;
        repeat (4) @(negedge clk_pixel);
        check("fast_overrun_early", s_overrun, 0);
        repeat (10) @(negedge clk_pixel);
        check("fast_overrun_sticky", s_overrun, 1);
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk_pixel);
        check_reset_outputs("reset");
        release_reset();

        // Idle frames: silence, period and PROM strobe count checked by the monitor.
        repeat (3) frame(10'h000);

        // Voice 0 full scale, freq 0x02000: PROM phase field steps by one per frame.
        reg_write(5'h15, 4'hF);
        reg_write(5'h05, 4'h0);
        reg_write(5'h13, 4'h2);
        rom_data_a = 4'hF;
        for (int f = 0; f < 3; f++) begin
            push_addrs(8'(f), 8'h00, 8'h00);
            frame(10'h078);
        end

`ifdef WSG_MUTE_MASK_EN
        mute_mask = 3'b001;
        push_addrs(8'h03, 8'h00, 8'h00);
        frame(10'h000);
        push_addrs(8'h04, 8'h00, 8'h00);
        frame(10'h000);
        mute_mask = 3'b000;
`endif

        // All voices at full volume: both mix extremes, then PROM B selection via wave[3].
        reg_write(5'h1A, 4'hF);
        reg_write(5'h1F, 4'hF);
        rom_data_a = 4'h0;
        frame(10'h2C5);
        rom_data_a = 4'hF;
        frame(10'h168);
        reg_write(5'h05, 4'h8);
        rom_data_b = 4'h0;
        frame(10'h087);

        // Fresh phases: voice 0 freq FFFFF wraps; voice 1 must ignore reg[0x10].
        reset_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk_pixel);
        release_reset();
        for (int a = 16; a < 21; a++) reg_write(5'(a), 4'hF);
        reg_write(5'h16, 4'h5);
        reg_write(5'h17, 4'h5);
        reg_write(5'h18, 4'h1);
        push_addrs(8'h00, 8'h00, 8'h00);
        push_addrs(8'h1F, 8'h00, 8'h00);
        push_addrs(8'h1F, 8'h01, 8'h00);
        push_addrs(8'h1F, 8'h01, 8'h00);
        repeat (4) frame(10'h000);

        // Volume write coinciding with the voice 1 latch is deferred by one frame.
        reg_write(5'h1A, 4'hF);
        rom_data_a = 4'hF;
        frame(10'h078);
        exp_q.push_back(10'h078);
        repeat (963) @(negedge clk_pixel);
        check("latch_state", dbg_state, ADDR);
        check("latch_rom_rd", rom_rd, 1);
        reg_write(5'h1A, 4'h8);
        wait_valid();
        frame(10'h040);

        // Asynchronous reset in the middle of a voice 0 PROM wait.
        repeat (481) @(negedge clk_pixel);
        check("pre_reset_state", dbg_state, WAIT);
        check("pre_reset_sample", sample_out, 10'h040);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) @(negedge clk_pixel);
        release_reset();
        repeat (2) frame(10'h000);

        repeat (5) @(negedge clk_pixel);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
